// File: rtl/pixel_proc_pkg.sv
// Shared pixel-processing constants, the separable Gaussian kernel and a
// constant-coefficient shift-add multiplier.
package pixel_proc_pkg;

  localparam int PIX_W        = 8;
  localparam int WIN_DIM      = 5;
  localparam int WIN_TAPS     = WIN_DIM * WIN_DIM;
  localparam int WEIGHT_SHIFT = 8;
  localparam int PROD_W       = 14;
  localparam int ROW_W        = 16;
  localparam int SUM_W        = 17;

  localparam int unsigned GAUSS_A [WIN_DIM] = '{1, 4, 6, 4, 1};

  typedef logic [PIX_W-1:0] pixel_t;

  // Weights are elaboration-time constants, so the unused adders fold away.
  function automatic logic [PROD_W-1:0] shift_add_mul(input pixel_t pix, input int unsigned weight);
    logic [PROD_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 6; b++) begin
      if (weight[b]) acc = acc + (PROD_W'(pix) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gauss_row5.sv
// One kernel row: registered weighted products (stage 1), then registered row sum (stage 2).
// Two cycles latency; free-running, no backpressure.
module gauss_row5
  import pixel_proc_pkg::*;
#(
  parameter int unsigned ROW_SCALE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  pixel_t [WIN_DIM-1:0]   taps,
  output logic [ROW_W-1:0]       row_sum
);

  logic [PROD_W-1:0] prod [WIN_DIM];
  logic [ROW_W-1:0]  sum_comb;

  always_comb begin
    sum_comb = '0;
    for (int c = 0; c < WIN_DIM; c++) sum_comb = sum_comb + ROW_W'(prod[c]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < WIN_DIM; c++) prod[c] <= '0;
      row_sum <= '0;
    end else begin
      for (int c = 0; c < WIN_DIM; c++) prod[c] <= shift_add_mul(taps[c], ROW_SCALE * GAUSS_A[c]);
      row_sum <= sum_comb;
    end
  end

endmodule

// File: rtl/window_gauss5x5.sv
// 5x5 Gaussian smoother with raster tracking; 3-cycle latency, no backpressure (valid travels with data).
// GAUSS_ROUND_EN selects round-half-up instead of truncation; border windows pass the centre tap.
module window_gauss5x5
  import pixel_proc_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [PIX_W*WIN_TAPS-1:0]   in_window,
  output logic                        out_valid,
  output pixel_t                      out_pixel,
  output logic                        out_border,
  output logic                        out_sof
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

`ifdef GAUSS_ROUND_EN
  localparam logic [SUM_W-1:0] ROUND_BIAS = SUM_W'(1 << (WEIGHT_SHIFT - 1));
`else
  localparam logic [SUM_W-1:0] ROUND_BIAS = '0;
`endif

  logic [CW-1:0] col, pos_col, nxt_col;
  logic [RW-1:0] row, pos_row, nxt_row;
  logic          border0;
  pixel_t        centre0;

  // col/row hold the position the next valid window will occupy.
  always_comb begin
    pos_col = col;
    pos_row = row;
    if (in_valid && in_sof) begin
      pos_col = '0;
      pos_row = '0;
    end
    nxt_col = pos_col + 1'b1;
    nxt_row = pos_row;
    if (pos_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
    end
    border0 = (32'(pos_row) < 32'd4) || (32'(pos_col) < 32'd4);
  end

  assign centre0 = in_window[(WIN_TAPS/2)*PIX_W +: PIX_W];

  logic   v1, v2, sof1, sof2, border1, border2;
  pixel_t centre1, centre2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col     <= '0;
      row     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      sof1    <= 1'b0;
      sof2    <= 1'b0;
      border1 <= 1'b0;
      border2 <= 1'b0;
      centre1 <= '0;
      centre2 <= '0;
    end else begin
      if (in_valid) begin
        col <= nxt_col;
        row <= nxt_row;
      end
      v1      <= in_valid;
      sof1    <= in_valid && in_sof;
      border1 <= border0;
      centre1 <= centre0;
      v2      <= v1;
      sof2    <= sof1;
      border2 <= border1;
      centre2 <= centre1;
    end
  end

  logic [ROW_W-1:0] row_sum [WIN_DIM];

  for (genvar r = 0; r < WIN_DIM; r++) begin : g_row
    gauss_row5 #(.ROW_SCALE(GAUSS_A[r])) u_row (
      .clk     (clk),
      .rst     (rst),
      .taps    (in_window[r*WIN_DIM*PIX_W +: WIN_DIM*PIX_W]),
      .row_sum (row_sum[r])
    );
  end

  logic [SUM_W-1:0] total, shifted;
  pixel_t           filt;

  always_comb begin
    total = ROUND_BIAS;
    for (int r = 0; r < WIN_DIM; r++) total = total + SUM_W'(row_sum[r]);
    shifted = total >> WEIGHT_SHIFT;
    // Kernel sums to 256 so this never fires, but a saturating output is cheap insurance.
    filt = (shifted > SUM_W'(255)) ? 8'hFF : shifted[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_border <= 1'b0;
      out_sof    <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_pixel  <= border2 ? centre2 : filt;
        out_border <= border2;
        out_sof    <= sof2;
      end
    end
  end

endmodule

// File: tb/tb_window_gauss5x5.sv
// Randomised bench for window_gauss5x5 on a small 8x6 frame, checked every cycle
// against a plain-arithmetic reference, plus literal expectations for the key cases.
module tb_window_gauss5x5;

  localparam int W = 8;
  localparam int H = 6;
  localparam int A [5] = '{1, 4, 6, 4, 1};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [199:0] in_window = '0;
  logic         out_valid;
  logic [7:0]   out_pixel;
  logic         out_border;
  logic         out_sof;

  int total = 0;
  int bad   = 0;

  window_gauss5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_window  (in_window),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_border (out_border),
    .out_sof    (out_sof)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int pix;
    bit border;
    bit sof;
  } exp_t;

  exp_t hist [$];
  exp_t held;
  int   mcol = 0;
  int   mrow = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gauss_ref(input logic [199:0] w);
    int s;
    s = 0;
    for (int i = 0; i < 25; i++) s += A[i/5] * A[i%5] * int'(w[8*i +: 8]);
`ifdef GAUSS_ROUND_EN
    s += 128;
`endif
    s = s / 256;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic logic [199:0] rand_win();
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[8*i +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic logic [199:0] fill_win(input int v);
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[8*i +: 8] = 8'(v);
    return w;
  endfunction

  // Reference: each cycle's input becomes the visible output three rising edges later.
  always @(posedge clk) begin
    exp_t e;
    exp_t cur;
    int   pc;
    int   pr;
    cur = '{1'b0, 0, 1'b0, 1'b0};
    if (!rst) begin
      hist.delete();
      hist.push_back(cur);
      hist.push_back(cur);
      held = '{1'b0, 0, 1'b0, 1'b0};
      mcol = 0;
      mrow = 0;
    end else begin
      e = '{in_valid, 0, 1'b0, in_sof};
      if (in_valid) begin
        pc = in_sof ? 0 : mcol;
        pr = in_sof ? 0 : mrow;
        e.border = (pr < 4) || (pc < 4);
        e.pix = e.border ? int'(in_window[103:96]) : gauss_ref(in_window);
        mcol = pc + 1;
        mrow = pr;
        if (mcol == W) begin
          mcol = 0;
          mrow = (pr + 1 == H) ? 0 : pr + 1;
        end
      end
      hist.push_back(e);
      if (hist.size() > 0) cur = hist.pop_front();
    end
    if (cur.v) held = cur;
    #1;
    check("model_valid",  32'(out_valid),  32'(cur.v));
    check("model_pixel",  32'(out_pixel),  32'(held.pix));
    check("model_border", 32'(out_border), 32'(held.border));
    check("model_sof",    32'(out_sof),    32'(held.sof));
  end

  task automatic drive(input bit v, input bit s, input logic [199:0] w);
    in_valid  = v;
    in_sof    = s;
    in_window = w;
    @(negedge clk);
  endtask

  initial begin
    logic [199:0] w;
    int cnt_v;
    int cnt_nb;
    int impulse_exp;
`ifdef GAUSS_ROUND_EN
    impulse_exp = 36;
`else
    impulse_exp = 35;
`endif

    // Pin the reference itself on hand-computed cases.
    check("ref_uniform", 32'(gauss_ref(fill_win(100))), 32'd100);
    w = fill_win(0);
    w[103:96] = 8'hFF;
    check("ref_impulse", 32'(gauss_ref(w)), 32'(impulse_exp));
    check("ref_saturate", 32'(gauss_ref(fill_win(255))), 32'd255);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid",  32'(out_valid),  32'd0);
    check("reset_pixel",  32'(out_pixel),  32'd0);
    check("reset_border", 32'(out_border), 32'd0);
    check("reset_sof",    32'(out_sof),    32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);

    // Border: sof plus four more windows, all flagged and passing the centre tap.
    for (int i = 0; i < 7; i++) begin
      w = rand_win();
      w[103:96] = 8'h5A;
      if (i < 5) drive(1'b1, i == 0, w);
      else       drive(1'b0, 1'b0, w);
      if (i >= 2) begin
        check("border_valid", 32'(out_valid),  32'd1);
        check("border_flag",  32'(out_border), 32'd1);
        check("border_pixel", 32'(out_pixel),  32'h5A);
        check("border_sof",   32'(out_sof),    32'(i == 2));
      end
    end

    // Walk to (4,4) then uniform, impulse and saturation windows back to back.
    drive(1'b1, 1'b1, rand_win());
    for (int k = 1; k < 36; k++) drive(1'b1, 1'b0, rand_win());
    drive(1'b1, 1'b0, fill_win(100));
    w = fill_win(0);
    w[103:96] = 8'hFF;
    drive(1'b1, 1'b0, w);
    drive(1'b1, 1'b0, fill_win(255));
    check("uniform_valid",  32'(out_valid),  32'd1);
    check("uniform_pixel",  32'(out_pixel),  32'd100);
    check("uniform_border", 32'(out_border), 32'd0);
    drive(1'b0, 1'b0, '0);
    check("impulse_pixel",  32'(out_pixel),  32'(impulse_exp));
    check("impulse_border", 32'(out_border), 32'd0);
    drive(1'b0, 1'b0, '0);
    check("saturate_pixel", 32'(out_pixel),  32'd255);
    check("saturate_valid", 32'(out_valid),  32'd1);
    drive(1'b0, 1'b0, '0);

    // One full 8x6 frame with random gaps.
    cnt_v  = 0;
    cnt_nb = 0;
    for (int k = 0; k < 48; k++) begin
      drive(1'b1, k == 0, rand_win());
      cnt_v  += int'(out_valid);
      cnt_nb += int'(out_valid && !out_border);
      repeat ($urandom_range(0, 2)) begin
        drive(1'b0, 1'b0, rand_win());
        cnt_v  += int'(out_valid);
        cnt_nb += int'(out_valid && !out_border);
      end
    end
    repeat (3) begin
      drive(1'b0, 1'b0, '0);
      cnt_v  += int'(out_valid);
      cnt_nb += int'(out_valid && !out_border);
    end
    check("frame_valid_count",     32'(cnt_v),  32'd48);
    check("frame_nonborder_count", 32'(cnt_nb), 32'd8);

    // Without a new sof the 49th window restarts at (0,0); (4,4) lands 36 windows later.
    for (int k = 0; k <= 36; k++) drive(1'b1, 1'b0, (k == 36) ? fill_win(200) : rand_win());
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    check("wrap_pixel",  32'(out_pixel),  32'd200);
    check("wrap_border", 32'(out_border), 32'd0);

    // Random traffic, including sof without valid and occasional saturated windows.
    for (int k = 0; k < 1500; k++) begin
      w = ($urandom_range(0, 9) == 0) ? fill_win(255) : rand_win();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, w);
    end

    // Reset while a valid window is in flight.
    drive(1'b1, 1'b0, rand_win());
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("midreset_hold", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    w = fill_win(250);
    w[103:96] = 8'h77;
    drive(1'b1, 1'b0, w);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    check("post_reset_valid",  32'(out_valid),  32'd1);
    check("post_reset_border", 32'(out_border), 32'd1);
    check("post_reset_pixel",  32'(out_pixel),  32'h77);

    repeat (3) drive(1'b0, 1'b0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_gauss5x5.md
# window_gauss5x5

Pipelined 5x5 Gaussian smoothing stage that sits directly downstream of `pixel_window`. Each valid cycle it consumes one flattened 200-bit 5x5 neighbourhood and produces one filtered 8-bit pixel three cycles later. It tracks raster position so that windows not yet fully populated are flagged as border and passed through unfiltered.

## Interface
- `IMG_WIDTH`, default 640: pixels per line; counter wraps at `IMG_WIDTH-1`.
- `IMG_HEIGHT`, default 480: lines per frame; counter wraps at `IMG_HEIGHT-1`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `in_valid`  in  1  the window is valid this cycle.
- `in_sof`  in  1  start of frame; qualified by `in_valid`.
- `in_window`  in  200  tap i (i = 5*row + col) occupies `[8*i+7:8*i]`; row 0 and col 0 are the oldest; the centre tap is bits `[103:96]`.
- `out_valid`  out  1  `out_pixel` is valid.
- `out_pixel`  out  8  filtered pixel, or the centre tap when `out_border` is 1.
- `out_border`  out  1  the window was incomplete.
- `out_sof`  out  1  delayed `in_sof`.

## Operation
- Weight `w[r][c] = a[r]*a[c]`, with `a = {1,4,6,4,1}`. The weights sum to 256; the maximum weight is 36.
- Result: `sum(w*tap) >> 8`. The result is clamped to 255. The clamp is unreachable but is still implemented.
- Multiplies are shift-add only, with no DSP inference required.
- Widths:
  - products: 14-bit unsigned
  - row partials: 16-bit
  - final sum: 17-bit
- Position counters `col` and `row` advance only on `in_valid`:
  - `in_valid && in_sof` → this window is at (0,0); the next window is at col 1.
  - Otherwise `col++`. At `IMG_WIDTH-1`, `col` → 0 and `row++`. At `IMG_HEIGHT-1`, `row` → 0.
- Border rule: a window is border when `row < 4 || col < 4`, using the position of its newest pixel. For a border window, `out_pixel` = the centre tap, delayed to match latency, and `out_border` = 1.
- No backpressure. The pipeline advances every cycle, and the valid bit travels with its data. Bubbles on `in_valid` appear unchanged on `out_valid`.
- When `out_valid` = 0, `out_pixel`, `out_border` and `out_sof` hold their previous values.

## Timing
- Latency: exactly 3 cycles from an `in_valid` edge to `out_valid`. Throughput is 1 window per cycle.
- Stage 1 registers the 25 weighted products, the border flag, `sof` and the centre tap.
- Stage 2 registers the 5 row partial sums.
- Stage 3 registers the total, the rounding/shift and the clamp/mux.
- Reset: every output, all pipeline valid bits, `col` and `row` go to 0 immediately and asynchronously.
- Reset release: the first `in_valid` after release is treated as position (0,0) unless `in_sof` says otherwise. Data in flight at reset is discarded; `out_valid` is never 1 for it.
- `in_sof` mid-frame: counters resynchronise at that cycle and the previous frame's position is abandoned.
- `in_sof` with `in_valid` = 0 is ignored.

## Configuration
- `GAUSS_ROUND_EN`:
  - Defined: 128 is added before `>> 8`, giving round-half-up.
  - Undefined: the result is truncated.
- Latency and widths are identical in both builds.

## Structure
- Package `pixel_proc_pkg` holds:
  - `PIX_W` = 8
  - `WIN_DIM` = 5
  - `WIN_TAPS` = 25
  - the 1-D weight vector `{1,4,6,4,1}` and `WEIGHT_SHIFT` = 8
  - a `pixel_t` typedef
- Sub-module `gauss_row5` computes the weighted 5-tap sum for one window row, given that row's `a[r]` scale. It is instantiated 5 times. Its product stage is registered inside it (stage 1) and its sum is registered inside it (stage 2).

## Test plan
- **Uniform window:** all 25 taps = 100 at position (4,4) → after 3 cycles `out_valid`=1, `out_pixel`=100, `out_border`=0.
- **Impulse:** centre tap = 255, all others 0, at a non-border position → `out_pixel`=35 without `GAUSS_ROUND_EN`, 36 with it.
- **Saturation path:** all taps = 255 → `out_pixel`=255, with no wrap to 0.
- **Border:** `in_sof` followed by 5 consecutive windows with centre tap = 0x5A → outputs 1–5 (positions (0,0)–(4,0)) all have `out_border`=1, `out_pixel`=0x5A, and `out_sof`=1 on the first only.
- **Bubbles and wrap:** with `IMG_WIDTH`=8 and `IMG_HEIGHT`=6, drive 48 windows with random gaps → `out_valid` count = 48, and the gap pattern is preserved with a 3-cycle shift. `out_border`=0 only for rows 4–5 and cols 4–7, and the counter returns to (0,0) on window 49.
- **Reset mid-stream:** assert `rst`=0 one cycle after a valid window → `out_valid` is 0 immediately and stays 0. After release, the next window is treated as (0,0) and is border.
